hazard_stall_ctrl: RTL and testbench

- Stall, flush and freeze controller for the 5-stage MIPS pipeline.
- Operand forwarding fixes most register dependences. This block covers the cases forwarding cannot fix:
  - load-use dependence: hold PC and IF/ID, inject an ID/EX bubble;
  - taken branch resolved in EX: flush IF/ID and ID/EX;
  - multi-cycle data-memory access: freeze the whole pipeline until memory acks.
- Sits beside the datapath and drives the pipeline-register write enables, the flush controls and a stall performance counter.

---
 rtl/hazard_stall_ctrl_pkg.sv | 22 ++
 rtl/hazard_stall_ctrl_if.sv | 57 +++++
 rtl/hazard_stall_ctrl_load_use_detect.sv | 36 +++
 rtl/hazard_stall_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared constants for the MIPS pipeline hazard/stall controller:
//   controller state encoding, the hard-wired zero register number and the
//   default parameter values used by the top module.
// ----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    // Controller state encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    // $zero never carries a real dependence.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default parameter values.
    localparam int DEF_MEM_TIMEOUT  = 16;
    localparam int DEF_FLUSH_CYCLES = 1;
    localparam int DEF_CNT_W        = 16;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundle between the pipeline datapath (master) and the hazard/stall
//   controller (slave).
//
//   Signalling: there is no valid/ready handshake. Every signal is a level
//   sampled on each rising clk edge. The datapath presents the ID/EX/MEM
//   stage fields every cycle; the controller answers combinationally in the
//   same cycle with the pipeline-register enables and flush controls. A data
//   memory access is outstanding while MemReq=1 and MemReady=0; the cycle
//   with MemReady=1 completes it.
//
//   Datapath -> controller: Rs_ID, Rt_ID, UseRt_ID, Rd_EX, MemRead_EX,
//                           BranchTaken_EX, MemReq, MemReady
//   Controller -> datapath: PCWrite, IFIDWrite, IDEXBubble, IFIDFlush,
//                           Freeze, MemErr, StallCnt, dbg_state
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID / EX / MEM stage information
    logic [4:0]       Rs_ID;
    logic [4:0]       Rt_ID;
    logic             UseRt_ID;
    logic [4:0]       Rd_EX;
    logic             MemRead_EX;
    logic             BranchTaken_EX;
    logic             MemReq;
    logic             MemReady;

    // Pipeline controls
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXBubble;
    logic             IFIDFlush;
    logic             Freeze;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt;

    // Current controller state, for observation only
    logic [1:0]       dbg_state;

    modport master (
        output Rs_ID, Rt_ID, UseRt_ID, Rd_EX, MemRead_EX,
               BranchTaken_EX, MemReq, MemReady,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Freeze,
               MemErr, StallCnt, dbg_state
    );

    modport slave (
        input  Rs_ID, Rt_ID, UseRt_ID, Rd_EX, MemRead_EX,
               BranchTaken_EX, MemReq, MemReady,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Freeze,
               MemErr, StallCnt, dbg_state
    );

endinterface : hazard_stall_ctrl_if

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_load_use_detect
//   Purely combinational load-use hazard detector. Flags the case where the
//   instruction in EX is a load whose destination is a source of the
//   instruction in ID; forwarding cannot cover this because the load data
//   only exists after MEM.
//
//   Ports:
//     Rs_ID, Rt_ID  in  source register fields of the ID instruction
//     UseRt_ID      in  ID instruction actually reads rt
//     Rd_EX         in  destination of the EX instruction
//     MemRead_EX    in  EX instruction is a load
//     lu            out load-use hazard present
// ----------------------------------------------------------------------------
module hazard_stall_ctrl_load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       UseRt_ID,
    input  logic [4:0] Rd_EX,
    input  logic       MemRead_EX,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (Rd_EX == Rs_ID);
    // rt only matters when the ID instruction reads it (I-type loads/ALU-imm
    // write rt instead of reading it).
    assign rt_hit = UseRt_ID && (Rd_EX == Rt_ID);

    assign lu = MemRead_EX && (Rd_EX != REG_ZERO) && (rs_hit || rt_hit);

endmodule : hazard_stall_ctrl_load_use_detect

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Stall / flush / freeze controller for the 5-stage MIPS pipeline.
//   Handles what operand forwarding cannot:
//     - load-use: hold PC and IF/ID for one cycle, bubble ID/EX
//     - taken branch in EX: flush IF/ID and ID/EX for FLUSH_CYCLES cycles
//     - multi-cycle data memory: freeze the whole pipeline until MemReady
//   Also keeps a sticky memory-timeout flag and a saturating count of
//   cycles in which the PC was held.
//
//   Ports:
//     clk  in  pipeline clock
//     rst  in  synchronous active-high reset
//     bus  slave side of hazard_stall_ctrl_if (stage fields in, controls out)
//
//   Parameters:
//     FLUSH_CYCLES  flush length after a taken branch (1..3)
//     MEM_TIMEOUT   consecutive memory-wait cycles before MemErr is raised
//     CNT_W         StallCnt width (must match the interface CNT_W)
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);

    localparam int               TMO_W        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX      = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE      = TMO_W'(1);
    localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       flush_cnt_q, flush_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             lu;
    logic             mem_stall;
    logic [TMO_W-1:0] tmo_inc;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             freeze;

    hazard_stall_ctrl_load_use_detect u_load_use_detect (
        .Rs_ID      (bus.Rs_ID),
        .Rt_ID      (bus.Rt_ID),
        .UseRt_ID   (bus.UseRt_ID),
        .Rd_EX      (bus.Rd_EX),
        .MemRead_EX (bus.MemRead_EX),
        .lu         (lu)
    );

    assign mem_stall = bus.MemReq && !bus.MemReady;
    assign tmo_inc   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_ONE;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_d       = tmo_q;
        mem_err_d   = mem_err_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        freeze      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    // Memory wait outranks everything: nothing may move.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    tmo_d      = TMO_ONE;
                end else if (bus.BranchTaken_EX) begin
                    // Redirect fetch; the ID instruction is wrong-path, so
                    // a coincident load-use hazard is irrelevant.
                    idex_bubble = 1'b1;
                    ifid_flush  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (lu) begin
                    // One-cycle stall: the bubble removes the load from EX,
                    // so lu is gone next cycle.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // EX is frozen, so branch and load-use are re-evaluated
                // only after returning to RUN.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                freeze     = 1'b1;
                if (bus.MemReady) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            ST_FLUSH: begin
                idex_bubble = 1'b1;
                ifid_flush  = 1'b1;
                if (mem_stall) begin
                    // Remaining wrong-path slots are already bubbles.
                    state_d     = ST_MEM_WAIT;
                    flush_cnt_d = '0;
                    tmo_d       = TMO_ONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q == 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
                tmo_d       = '0;
            end
        endcase

        // The flag latches on the cycle the wait counter lands on the limit.
        if (tmo_d == TMO_MAX) begin
            mem_err_d = 1'b1;
        end

        // Reset forces a safe pipeline: nothing advances, both front
        // registers are cleared to NOP.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            freeze      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, counters and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            tmo_q       <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_q       <= tmo_d;
            mem_err_q   <= mem_err_d;
            if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.IFIDWrite  = ifid_write;
    assign bus.IDEXBubble = idex_bubble;
    assign bus.IFIDFlush  = ifid_flush;
    assign bus.Freeze     = freeze;
    assign bus.MemErr     = mem_err_q;
    assign bus.StallCnt   = stall_cnt_q;
    assign bus.dbg_state  = state_q;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=16).
//   The driver applies one cycle of inputs, evaluates the reference model for
//   that cycle and queues the expected control word; the monitor pops and
//   compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int FC  = 2;
    localparam int TMO = 16;
    localparam int CW  = 16;
    localparam int W   = 6 + CW;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_stall_ctrl #(
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (TMO),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // frozen     : a memory access is outstanding
    // flush_left : further flush cycles still owed after a taken branch
    // wait_len   : consecutive cycles spent with memory not ready
    bit m_frozen;
    int m_flush_left;
    int m_wait_len;
    bit m_err;
    int m_stalls;

    function automatic void model_reset();
        m_frozen     = 1'b0;
        m_flush_left = 0;
        m_wait_len   = 0;
        m_err        = 1'b0;
        m_stalls     = 0;
    endfunction

    function automatic void start_wait();
        m_frozen   = 1'b1;
        m_wait_len = 1;
        if (m_wait_len >= TMO) m_err = 1'b1;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                        input bit use_rt, input logic [4:0] rd, input bit mrd,
                        input bit br, input bit mreq, input bit mrdy);
        bit lu, ms;
        bit pcw, ifw, bub, fl, frz;
        @(posedge clk);
        #1;
        rst                = r;
        bus.Rs_ID          = rs;
        bus.Rt_ID          = rt;
        bus.UseRt_ID       = use_rt;
        bus.Rd_EX          = rd;
        bus.MemRead_EX     = mrd;
        bus.BranchTaken_EX = br;
        bus.MemReq         = mreq;
        bus.MemReady       = mrdy;

        lu = mrd && (rd != 5'd0) && ((rd == rs) || (use_rt && (rd == rt)));
        ms = mreq && !mrdy;
        // normal flow unless a rule below says otherwise
        pcw = 1; ifw = 1; bub = 0; fl = 0; frz = 0;

        if (r) begin
            pcw = 0; ifw = 0; bub = 1; fl = 1; frz = 0;
            exp_q.push_back({pcw, ifw, bub, fl, frz, m_err, CW'(m_stalls)});
            model_reset();
        end else begin
            if (m_frozen) begin
                pcw = 0; ifw = 0; frz = 1;
            end else if (m_flush_left > 0) begin
                bub = 1; fl = 1;
            end else if (ms) begin
                pcw = 0; ifw = 0; frz = 1;
            end else if (br) begin
                bub = 1; fl = 1;
            end else if (lu) begin
                pcw = 0; ifw = 0; bub = 1;
            end
            exp_q.push_back({pcw, ifw, bub, fl, frz, m_err, CW'(m_stalls)});

            // advance the model to the next cycle
            if (m_frozen) begin
                if (mrdy) begin
                    m_frozen   = 1'b0;
                    m_wait_len = 0;
                end else begin
                    if (m_wait_len < TMO) m_wait_len++;
                    if (m_wait_len >= TMO) m_err = 1'b1;
                end
            end else if (m_flush_left > 0) begin
                if (ms) begin
                    m_flush_left = 0;
                    start_wait();
                end else begin
                    m_flush_left--;
                end
            end else if (ms) begin
                start_wait();
            end else if (br) begin
                m_flush_left = FC - 1;
            end
            if (!pcw && (m_stalls < CNT_MAX)) m_stalls++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0);
    endtask

    task automatic mem_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 1, rdy);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp_w, act_w;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                act_w = {bus.PCWrite, bus.IFIDWrite, bus.IDEXBubble,
                         bus.IFIDFlush, bus.Freeze, bus.MemErr, bus.StallCnt};
                n_cmp++;
                if (act_w !== exp_w) begin
                    n_err++;
                    $display("FAIL ctrl_word t=%0t got pcw/ifw/bub/fl/frz/err=%b cnt=%0d want %b cnt=%0d",
                             $time, act_w[W-1:CW], act_w[CW-1:0],
                             exp_w[W-1:CW], exp_w[CW-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r, ur, mrd, br, mreq, mrdy;
        logic [4:0] rs, rt, rd;

        rst                = 1'b1;
        bus.Rs_ID          = '0;
        bus.Rt_ID          = '0;
        bus.UseRt_ID       = 1'b0;
        bus.Rd_EX          = '0;
        bus.MemRead_EX     = 1'b0;
        bus.BranchTaken_EX = 1'b0;
        bus.MemReq         = 1'b0;
        bus.MemReady       = 1'b0;
        model_reset();
        // registers are unknown until the first reset edge: not checked
        repeat (2) @(posedge clk);

        // reset state
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);

        // load-use on rs: one stall cycle, StallCnt 0 -> 1
        step(0, 5'd8, 5'd2, 0, 5'd8, 1, 0, 0, 0);
        step(0, 5'd8, 5'd2, 0, 5'd8, 0, 0, 0, 0);
        idle(1);

        // $zero destination and unused rt: no stall
        step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
        step(0, 5'd1, 5'd9, 0, 5'd9, 1, 0, 0, 0);
        // rt dependence that does count
        step(0, 5'd1, 5'd9, 1, 5'd9, 1, 0, 0, 0);

        // branch with coincident load-use: 2 flush cycles then normal
        step(0, 5'd8, 5'd2, 0, 5'd8, 1, 1, 0, 0);
        idle(3);

        // memory wait: 3 not-ready cycles, then ready
        mem_cycles(3, 0);
        mem_cycles(1, 1);
        idle(2);

        // timeout: 20 not-ready cycles, flag stays after ready
        mem_cycles(20, 0);
        mem_cycles(1, 1);
        idle(2);
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        idle(1);

        // reset in the middle of a memory wait
        mem_cycles(3, 0);
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        idle(2);

        // branch followed by a memory stall during the flush
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0);
        mem_cycles(2, 0);
        mem_cycles(1, 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            r    = ($urandom_range(0, 99) < 2);
            rs   = 5'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            ur   = $urandom_range(0, 1) == 1;
            mrd  = $urandom_range(0, 1) == 1;
            br   = ($urandom_range(0, 99) < 15);
            mreq = ($urandom_range(0, 99) < 20);
            mrdy = ($urandom_range(0, 99) < 55);
            step(r, rs, rt, ur, rd, mrd, br, mreq, mrdy);
        end

        // drain: every queued expectation must have been checked
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
